// File: rtl/microroc_emu_pkg.sv
// Shared definitions for the Microroc ASIC digital-side emulator:
// FSM state encoding, frame geometry and the frame packing helper.
package microroc_emu_pkg;

  localparam int FRAME_BITS = 24;
  localparam int INDEX_BITS = 8;
  localparam int BCID_BITS  = 16;

  // Frame layout: {index, bcid}, bcid in the low bits
  localparam int BCID_LSB  = 0;
  localparam int INDEX_LSB = BCID_LSB + BCID_BITS;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ACQ     = 3'd1;
  localparam logic [2:0] ST_HOLD    = 3'd2;
  localparam logic [2:0] ST_WAIT_RO = 3'd3;
  localparam logic [2:0] ST_TX      = 3'd4;
  localparam logic [2:0] ST_END     = 3'd5;

  function automatic logic [FRAME_BITS-1:0] make_frame(
    input logic [INDEX_BITS-1:0] index,
    input logic [BCID_BITS-1:0]  bcid
  );
    make_frame = {index, bcid};
  endfunction

endpackage

// File: rtl/frame_serializer.sv
// Loads one frame word and shifts it out MSB first, one bit per cycle.
// last_bit is high during the cycle the final bit is on the output so the
// controlling FSM can reload back-to-back without a gap.
module frame_serializer
  import microroc_emu_pkg::*;
(
  input  logic                  Clk,
  input  logic                  clear,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] word,
  output logic                  bit_out,
  output logic                  active,
  output logic                  last_bit
);

  localparam logic [4:0] LAST_IDX = 5'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] shift_r;
  logic [4:0]            bit_cnt_r;
  logic                  active_r;

  // Shift register: clear, load a new word, or shift toward the MSB
  always_ff @(posedge Clk) begin
    if (clear) begin
      shift_r   <= {FRAME_BITS{1'b0}};
      bit_cnt_r <= 5'd0;
      active_r  <= 1'b0;
    end else if (load) begin
      shift_r   <= word;
      bit_cnt_r <= 5'd0;
      active_r  <= 1'b1;
    end else if (active_r) begin
      // After the final shift the register is all zeros, so the line idles low
      shift_r <= {shift_r[FRAME_BITS-2:0], 1'b0};
      if (bit_cnt_r == LAST_IDX) begin
        bit_cnt_r <= 5'd0;
        active_r  <= 1'b0;
      end else begin
        bit_cnt_r <= bit_cnt_r + 5'd1;
      end
    end else begin
      shift_r   <= shift_r;
      bit_cnt_r <= bit_cnt_r;
      active_r  <= active_r;
    end
  end

  assign bit_out  = shift_r[FRAME_BITS-1];
  assign active   = active_r;
  assign last_bit = active_r && (bit_cnt_r == LAST_IDX);

endmodule

// File: rtl/microroc_asic_emulator.sv
// Behavioural model of the Microroc ASIC digital side as seen by the DAQ
// controller: emulated hits during acquisition, a conversion pulse on
// Chipsatb, serial readout of stored frames and an End_Readout pulse.
module microroc_asic_emulator
  import microroc_emu_pkg::*;
#(
  parameter int MEM_DEPTH   = 8,
  parameter int HIT_PERIOD  = 4,
  parameter int CONV_CYCLES = 10,
  parameter int END_PULSE   = 4
)
(
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       Reset_b,
  input  logic       Start_Acq,
  input  logic       Start_Readout,
  input  logic       Pwr_on_d,
  output logic       Chipsatb,
  output logic       End_Readout,
  output logic       Dout,
  output logic       TransmitOn,
  output logic [7:0] Frame_count
);

  localparam int          ADDR_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [15:0] HIT_LAST   = 16'(HIT_PERIOD - 1);
  localparam logic [15:0] CONV_LAST  = 16'(CONV_CYCLES - 1);
  localparam logic [15:0] END_LAST   = 16'(END_PULSE - 1);
  localparam logic [7:0]  DEPTH_LAST = 8'(MEM_DEPTH - 1);

  logic [FRAME_BITS-1:0] mem_r [0:MEM_DEPTH-1];

  logic [2:0]  state_r;
  logic [15:0] bcid_r;
  logic [15:0] hit_cnt_r;
  logic [15:0] timer_r;
  logic [7:0]  frame_count_r;
  logic [7:0]  rd_idx_r;
  logic        chipsatb_r;
  logic        end_ro_r;
  logic        start_ro_prev_r;

  logic                  rst_s;
  logic                  ro_rise_s;
  logic                  store_s;
  logic                  full_s;
  logic                  ser_load_s;
  logic                  ser_clear_s;
  logic [FRAME_BITS-1:0] ser_word_s;
  logic                  ser_bit_s;
  logic                  ser_active_s;
  logic                  ser_last_s;

  // Hit storage, readout edge detection and serializer feed decisions
  always_comb begin
    rst_s       = !reset_n || !Reset_b;
    ro_rise_s   = Start_Readout && !start_ro_prev_r;
    store_s     = 1'b0;
    full_s      = 1'b0;
    ser_load_s  = 1'b0;
    ser_clear_s = rst_s;
    ser_word_s  = {FRAME_BITS{1'b0}};
    if (!rst_s) begin
      case (state_r)
        ST_ACQ: begin
          store_s = (hit_cnt_r == HIT_LAST) && Pwr_on_d;
          full_s  = store_s && (frame_count_r == DEPTH_LAST);
        end
        ST_WAIT_RO: begin
          if (ro_rise_s && (frame_count_r != 8'd0)) begin
            ser_load_s = 1'b1;
            ser_word_s = mem_r[0];
          end else begin
            ser_load_s = 1'b0;
          end
        end
        ST_TX: begin
          if (ser_last_s && (rd_idx_r != frame_count_r)) begin
            ser_load_s = 1'b1;
            ser_word_s = mem_r[rd_idx_r[ADDR_W-1:0]];
          end else begin
            ser_load_s = 1'b0;
          end
        end
        default: begin
          ser_load_s = 1'b0;
        end
      endcase
    end else begin
      ser_load_s = 1'b0;
    end
  end

  // Frame memory: written at the current fill address on each accepted hit
  always_ff @(posedge Clk) begin
    if (store_s) begin
      mem_r[frame_count_r[ADDR_W-1:0]] <= make_frame(frame_count_r, bcid_r);
    end
  end

  // Main FSM: acquisition, conversion hold, readout and end pulse
  always_ff @(posedge Clk) begin
    if (rst_s) begin
      state_r         <= ST_IDLE;
      bcid_r          <= 16'd0;
      hit_cnt_r       <= 16'd0;
      timer_r         <= 16'd0;
      frame_count_r   <= 8'd0;
      rd_idx_r        <= 8'd0;
      chipsatb_r      <= 1'b1;
      end_ro_r        <= 1'b0;
      start_ro_prev_r <= 1'b0;
    end else begin
      start_ro_prev_r <= Start_Readout;
      case (state_r)
        ST_IDLE: begin
          if (Start_Acq) begin
            state_r       <= ST_ACQ;
            bcid_r        <= 16'd0;
            hit_cnt_r     <= 16'd0;
            frame_count_r <= 8'd0;
          end
        end
        ST_ACQ: begin
          bcid_r <= bcid_r + 16'd1;
          if (hit_cnt_r == HIT_LAST) begin
            hit_cnt_r <= 16'd0;
          end else begin
            hit_cnt_r <= hit_cnt_r + 16'd1;
          end
          if (store_s) begin
            frame_count_r <= frame_count_r + 8'd1;
          end
          // A store on the exit edge still completes before the hold
          if (!Start_Acq || full_s) begin
            state_r    <= ST_HOLD;
            chipsatb_r <= 1'b0;
            timer_r    <= 16'd0;
          end
        end
        ST_HOLD: begin
          if (timer_r == CONV_LAST) begin
            chipsatb_r <= 1'b1;
            state_r    <= ST_WAIT_RO;
          end else begin
            timer_r <= timer_r + 16'd1;
          end
        end
        ST_WAIT_RO: begin
          if (ro_rise_s) begin
            state_r  <= ST_TX;
            rd_idx_r <= 8'd1;
          end
        end
        ST_TX: begin
          if ((frame_count_r == 8'd0) || (ser_last_s && (rd_idx_r == frame_count_r))) begin
            state_r  <= ST_END;
            end_ro_r <= 1'b1;
            timer_r  <= 16'd0;
          end else if (ser_last_s) begin
            rd_idx_r <= rd_idx_r + 8'd1;
          end
        end
        ST_END: begin
          if (timer_r == END_LAST) begin
            end_ro_r      <= 1'b0;
            frame_count_r <= 8'd0;
            state_r       <= ST_IDLE;
          end else begin
            timer_r <= timer_r + 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  frame_serializer u_serializer (
    .Clk      (Clk),
    .clear    (ser_clear_s),
    .load     (ser_load_s),
    .word     (ser_word_s),
    .bit_out  (ser_bit_s),
    .active   (ser_active_s),
    .last_bit (ser_last_s)
  );

  assign Chipsatb    = chipsatb_r;
  assign End_Readout = end_ro_r;
  assign Frame_count = frame_count_r;
  assign Dout        = ser_bit_s;
  assign TransmitOn  = ser_active_s;

endmodule

// File: tb/tb_microroc_asic_emulator.sv
// Self-checking bench for microroc_asic_emulator: table-driven scenarios plus
// randomized acquisitions, checked cycle by cycle against an arithmetic model.
module tb_microroc_asic_emulator;

  localparam int MEM_DEPTH   = 8;
  localparam int HIT_PERIOD  = 4;
  localparam int CONV_CYCLES = 10;
  localparam int END_PULSE   = 4;

  logic       Clk = 1'b0;
  logic       reset_n, Reset_b, Start_Acq, Start_Readout, Pwr_on_d;
  logic       Chipsatb, End_Readout, Dout, TransmitOn;
  logic [7:0] Frame_count;

  int checks   = 0;
  int failures = 0;

  microroc_asic_emulator #(
    .MEM_DEPTH(MEM_DEPTH), .HIT_PERIOD(HIT_PERIOD),
    .CONV_CYCLES(CONV_CYCLES), .END_PULSE(END_PULSE)
  ) dut (
    .Clk(Clk), .reset_n(reset_n), .Reset_b(Reset_b), .Start_Acq(Start_Acq),
    .Start_Readout(Start_Readout), .Pwr_on_d(Pwr_on_d), .Chipsatb(Chipsatb),
    .End_Readout(End_Readout), .Dout(Dout), .TransmitOn(TransmitOn),
    .Frame_count(Frame_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int acq_len;       // edges with Start_Acq high
    int pwr_mode;      // 0 all low, 1 all high, 2 random
    int ro_glitch_at;  // Start_Readout pulse during ACQ (-1 none)
    int abort_at;      // readout cycle at which Reset_b is pulsed (-1 none)
    int exp_frames;
    int exp_last_bcid;
  } vec_t;

  vec_t vecs [0:6];
  bit   pwr_a [0:255];
  int   exp_bcid [0:15];
  int   exp_n;
  int   tx_high_cnt;
  int   rx_last_bcid;

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  // Acquisition: expected stores come from hit period arithmetic over the Pwr_on_d pattern
  task automatic run_acq(input int len, input int mode, input int glitch_at);
    int store_edge [0:15];
    int exit_i, last_i, cnt;
    for (int k = 0; k < 256; k++)
      pwr_a[k] = (mode == 1) ? 1'b1 : (mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
    exp_n  = 0;
    exit_i = len;
    for (int j = 1; (j * HIT_PERIOD <= len) && (exp_n < MEM_DEPTH); j++) begin
      if (pwr_a[j * HIT_PERIOD]) begin
        exp_bcid[exp_n]   = j * HIT_PERIOD - 1;
        store_edge[exp_n] = j * HIT_PERIOD;
        exp_n++;
        if (exp_n == MEM_DEPTH) exit_i = j * HIT_PERIOD;
      end
    end
    last_i = (len > exit_i + CONV_CYCLES + 2) ? len : exit_i + CONV_CYCLES + 2;
    for (int i = 0; i <= last_i; i++) begin
      Start_Acq     = (i < len);
      Pwr_on_d      = pwr_a[i];
      Start_Readout = (glitch_at >= 0) && ((i == glitch_at) || (i == glitch_at + 1));
      step();
      cnt = 0;
      for (int k = 0; k < exp_n; k++) if (store_edge[k] <= i) cnt++;
      chk("acq_frame_count", i, 32'(Frame_count), cnt);
      chk("acq_chipsatb", i, 32'(Chipsatb), ((i >= exit_i) && (i < exit_i + CONV_CYCLES)) ? 0 : 1);
      chk("acq_transmit_on", i, 32'(TransmitOn), 0);
    end
    Start_Readout = 1'b0;
    Pwr_on_d      = 1'b0;
  endtask

  // Readout: expected serial stream is the stored frame list, 24 bits each, MSB first
  task automatic do_readout(input int abort_at);
    int e, last_i, rx_bits;
    logic        exp_tx, exp_dout;
    logic [23:0] w, rx_word;
    e            = (exp_n > 0) ? exp_n * 24 : 1;
    last_i       = e + END_PULSE + 2;
    tx_high_cnt  = 0;
    rx_last_bcid = -1;
    rx_bits      = 0;
    rx_word      = 24'd0;
    Start_Readout = 1'b1;
    for (int i = 0; i <= last_i; i++) begin
      if (i == 16) Start_Readout = 1'b0;
      if (i == abort_at) Reset_b = 1'b0;
      step();
      if (i == abort_at) begin
        Reset_b = 1'b1;
        chk("abort_chipsatb", i, 32'(Chipsatb), 1);
        chk("abort_end_readout", i, 32'(End_Readout), 0);
        chk("abort_dout", i, 32'(Dout), 0);
        chk("abort_transmit_on", i, 32'(TransmitOn), 0);
        chk("abort_frame_count", i, 32'(Frame_count), 0);
        break;
      end
      exp_tx   = (i < exp_n * 24);
      w        = {8'(i / 24), 16'(exp_bcid[i / 24])};
      w        = w << (i % 24);
      exp_dout = exp_tx ? w[23] : 1'b0;
      chk("ro_transmit_on", i, 32'(TransmitOn), 32'(exp_tx));
      chk("ro_dout", i, 32'(Dout), 32'(exp_dout));
      chk("ro_end_readout", i, 32'(End_Readout), ((i >= e) && (i < e + END_PULSE)) ? 1 : 0);
      chk("ro_frame_count", i, 32'(Frame_count), (i < e + END_PULSE) ? exp_n : 0);
      chk("ro_chipsatb", i, 32'(Chipsatb), 1);
      if (TransmitOn === 1'b1) begin
        tx_high_cnt++;
        rx_word = {rx_word[22:0], Dout};
        rx_bits++;
        if (rx_bits % 24 == 0) rx_last_bcid = int'(rx_word[15:0]);
      end
    end
    Start_Readout = 1'b0;
  endtask

  initial begin
    int len;
    reset_n       = 1'b0;
    Reset_b       = 1'b1;
    Start_Acq     = 1'b0;
    Start_Readout = 1'b0;
    Pwr_on_d      = 1'b0;

    vecs[0] = '{20,  1, -1, -1, 5, 19};
    vecs[1] = '{100, 1, -1, -1, 8, 31};
    vecs[2] = '{20,  0, -1, -1, 0, 0};
    vecs[3] = '{22,  1,  6, -1, 5, 19};
    vecs[4] = '{4,   1, -1, -1, 1, 3};
    vecs[5] = '{3,   1, -1, -1, 0, 0};
    vecs[6] = '{20,  1, -1, 30, 5, 19};

    @(negedge Clk);
    step();
    step();
    chk("reset_chipsatb", 0, 32'(Chipsatb), 1);
    chk("reset_end_readout", 0, 32'(End_Readout), 0);
    chk("reset_dout", 0, 32'(Dout), 0);
    chk("reset_transmit_on", 0, 32'(TransmitOn), 0);
    chk("reset_frame_count", 0, 32'(Frame_count), 0);
    reset_n = 1'b1;
    step();

    for (int v = 0; v < 7; v++) begin
      run_acq(vecs[v].acq_len, vecs[v].pwr_mode, vecs[v].ro_glitch_at);
      chk("table_frames", v, 32'(Frame_count), vecs[v].exp_frames);
      do_readout(vecs[v].abort_at);
      if (vecs[v].abort_at < 0) begin
        chk("table_tx_len", v, tx_high_cnt, vecs[v].exp_frames * 24);
        if (vecs[v].exp_frames > 0)
          chk("table_last_bcid", v, rx_last_bcid, vecs[v].exp_last_bcid);
      end else begin
        // Readout edge after an abort must not restart transmission
        step();
        Start_Readout = 1'b1;
        for (int i = 0; i < 30; i++) begin
          step();
          chk("post_abort_transmit_on", i, 32'(TransmitOn), 0);
          chk("post_abort_end_readout", i, 32'(End_Readout), 0);
          chk("post_abort_frame_count", i, 32'(Frame_count), 0);
        end
        Start_Readout = 1'b0;
        step();
      end
    end

    for (int r = 0; r < 5; r++) begin
      len = $urandom_range(1, 60);
      run_acq(len, 2, -1);
      do_readout(-1);
      chk("rand_tx_len", r, tx_high_cnt, exp_n * 24);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
